i2s_clkgen: RTL

Parametrised I2S/TDM serial-clock and word-select generator for the transceiver's master-mode path. It replaces the fixed divide-by-3 clock divider and the stereo-only word-select generator/tracker with one block. That block provides a programmable divider, a runtime-selectable 16/24/32-bit slot width, stereo-I2S or N-slot TDM framing, and registered edge strobes. The serializer/deserializer and control FSM consume its `sclk_fall`/`sclk_rise` strobes, `bit_cnt`, `slot` and `ws_change`.

---
 rtl/i2s_clkgen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/i2s_clkgen.sv
// Master-mode I2S/TDM bit-clock and word-select generator with a programmable
// divider, 16/24/32-bit slots, stereo or NCH-slot framing and one-cycle edge strobes.
module i2s_clkgen #(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned NCH    = 8,
  localparam int unsigned SLOT_W = $clog2(NCH)
) (
  input  logic              pclk,
  input  logic              rst_,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic [1:0]        frame_size,
  input  logic              tdm,
  output logic              sclk,
  output logic              sclk_rise,
  output logic              sclk_fall,
  output logic              ws,
  output logic              ws_change,
  output logic [4:0]        bit_cnt,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_start
);

  localparam int unsigned BIT_W = 5;
  localparam logic [SLOT_W-1:0] SLOT_LAST_TDM = SLOT_W'(NCH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST_I2S = SLOT_W'(1);

  logic              run_q, run_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              sclk_q, sclk_d;
  logic              sclk_rise_q, sclk_rise_d;
  logic              sclk_fall_q, sclk_fall_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              ws_q, ws_d;
  logic              ws_change_q, ws_change_d;
  logic              frame_start_q, frame_start_d;
  logic [DIV_W-1:0]  div_l_q, div_l_d;
  logic [1:0]        fsize_l_q, fsize_l_d;
  logic              mode_l_q, mode_l_d;

  logic [BIT_W-1:0]  bit_last;
  logic [SLOT_W-1:0] slot_last;
  logic              tick, fall_now, bit_end, slot_end, pre_last, wrap;

  // Frame geometry and edge decode from the shadowed configuration
  always_comb begin
    unique case (fsize_l_q)
      2'b00:   bit_last = BIT_W'(15);
      2'b01:   bit_last = BIT_W'(23);
      default: bit_last = BIT_W'(31);
    endcase
    slot_last = mode_l_q ? SLOT_LAST_TDM : SLOT_LAST_I2S;
    tick      = run_q && (div_cnt_q == div_l_q);
    fall_now  = tick && sclk_q;
    bit_end   = (bit_cnt_q == bit_last);
    slot_end  = (slot_q == slot_last);
    pre_last  = (bit_cnt_q == (bit_last - BIT_W'(1)));
    wrap      = fall_now && bit_end && slot_end;
  end

  // Next-state logic; en low is a synchronous clear that keeps tracking the config inputs
  always_comb begin
    run_d         = run_q;
    div_cnt_d     = div_cnt_q;
    sclk_d        = sclk_q;
    sclk_rise_d   = 1'b0;
    sclk_fall_d   = 1'b0;
    bit_cnt_d     = bit_cnt_q;
    slot_d        = slot_q;
    ws_d          = ws_q;
    ws_change_d   = 1'b0;
    frame_start_d = 1'b0;
    div_l_d       = div_l_q;
    fsize_l_d     = fsize_l_q;
    mode_l_d      = mode_l_q;

    if (!en) begin
      run_d     = 1'b0;
      div_cnt_d = '0;
      sclk_d    = 1'b0;
      bit_cnt_d = '0;
      slot_d    = '0;
      ws_d      = 1'b0;
      div_l_d   = div;
      fsize_l_d = frame_size;
      mode_l_d  = tdm;
    end else begin
      run_d = 1'b1;
      if (run_q) begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      end
      if (tick) begin
        sclk_d = ~sclk_q;
      end
      sclk_rise_d = tick && !sclk_q;
      sclk_fall_d = fall_now;

      if (fall_now) begin
        if (bit_end) begin
          bit_cnt_d = '0;
          slot_d    = slot_end ? '0 : slot_q + SLOT_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
        // ws leads the slot boundary by one bit; TDM sync is a one-bit pulse before slot 0
        if (mode_l_q) begin
          ws_d = pre_last && slot_end;
        end else if (pre_last) begin
          ws_d = (slot_q == '0);
        end
      end

      frame_start_d = wrap;
      ws_change_d   = ws_d ^ ws_q;

      if (wrap) begin
        div_l_d   = div;
        fsize_l_d = frame_size;
        mode_l_d  = tdm;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      run_q         <= 1'b0;
      div_cnt_q     <= '0;
      sclk_q        <= 1'b0;
      sclk_rise_q   <= 1'b0;
      sclk_fall_q   <= 1'b0;
      bit_cnt_q     <= '0;
      slot_q        <= '0;
      ws_q          <= 1'b0;
      ws_change_q   <= 1'b0;
      frame_start_q <= 1'b0;
      div_l_q       <= '0;
      fsize_l_q     <= '0;
      mode_l_q      <= 1'b0;
    end else begin
      run_q         <= run_d;
      div_cnt_q     <= div_cnt_d;
      sclk_q        <= sclk_d;
      sclk_rise_q   <= sclk_rise_d;
      sclk_fall_q   <= sclk_fall_d;
      bit_cnt_q     <= bit_cnt_d;
      slot_q        <= slot_d;
      ws_q          <= ws_d;
      ws_change_q   <= ws_change_d;
      frame_start_q <= frame_start_d;
      div_l_q       <= div_l_d;
      fsize_l_q     <= fsize_l_d;
      mode_l_q      <= mode_l_d;
    end
  end

  assign sclk        = sclk_q;
  assign sclk_rise   = sclk_rise_q;
  assign sclk_fall   = sclk_fall_q;
  assign ws          = ws_q;
  assign ws_change   = ws_change_q;
  assign bit_cnt     = bit_cnt_q;
  assign slot        = slot_q;
  assign frame_start = frame_start_q;

endmodule
